mul4_shift_add: RTL and testbench
=================================

MUL4_SHIFT_ADD -- requirements
Module: mul4_shift_add

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiplication; SHALL be sampled only in IDLE or DONE.
REQ-005 a  input  4  unsigned multiplicand; SHALL be captured on an accepted start.
REQ-006 b  input  4  unsigned multiplier; SHALL be captured on an accepted start.
REQ-007 p  output  8  unsigned product; SHALL be registered and valid from the done cycle until the next accepted start.
REQ-008 busy  output  1  high in RUN state only.
REQ-009 done  output  1  single-cycle pulse, high in DONE state only.
REQ-010 zero  output  1  high when the registered p equals 8'h00; SHALL be updated together with p.

Function
REQ-011 States SHALL be IDLE, RUN and DONE, encoded in a 2-bit state register.
REQ-012 Transitions SHALL be: IDLE -start-> RUN; RUN -(step count = 3)-> DONE; DONE -start-> RUN; DONE -!start-> IDLE.
REQ-013 An accepted start SHALL load mcand<=a, acc_hi<=4'h0, acc_lo<=b, step<=2'd0 and clear p and zero.
REQ-014 Each RUN cycle SHALL add mcand to acc_hi when acc_lo[0]=1 (add 4'h0 otherwise) through the 4-bit adder, giving a sum and a carry-out.
REQ-015 In the same RUN cycle, {carry, sum, acc_lo} SHALL be shifted right by one into {acc_hi, acc_lo}, and step SHALL be incremented.
REQ-016 The carry-in of the adder SHALL be tied to 0; the carry-out SHALL never be lost, because it is shifted into acc_hi[3].
REQ-017 On the RUN->DONE transition, p SHALL be loaded with {acc_hi, acc_lo} after the fourth shift, and zero SHALL be loaded with (that value == 0).
REQ-018 Latency: with start accepted at edge t, RUN SHALL occupy cycles t+1..t+4, and done=1 with p valid SHALL occur in cycle t+5 (5 cycles from start to done).
REQ-019 start SHALL be ignored while busy=1; a, b and start changes during RUN SHALL have no effect on the result.
REQ-020 start in the DONE cycle SHALL be accepted (back-to-back operation); done SHALL still pulse for exactly one cycle, and p SHALL then clear per REQ-013.
REQ-021 p SHALL hold its value in IDLE indefinitely.
REQ-022 The result SHALL be exact for all 256 operand pairs; the maximum is 15*15=225 (8'hE1), and no overflow condition exists.

Reset
REQ-023 rst=1 SHALL force state=IDLE, p=8'h00, zero=1, busy=0, done=0, step=0, and mcand, acc_hi and acc_lo all zero.
REQ-024 rst SHALL take priority over start and over any in-progress RUN step; an aborted operation SHALL produce no done pulse.
REQ-025 The first start SHALL be accepted at the first edge at which rst=0 and start=1.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE), the constant OP_W=4 and the constant STEPS=4.
REQ-027 The add step SHALL instantiate the team's existing 4-bit ripple adder as the single sub-module (operands n1, n2; sum s; carry Co; Overflow left unused).
REQ-028 No other sub-modules SHALL be used, and no combinational path SHALL run from inputs to outputs.

Verification
REQ-029 Reset then start with a=4'hF, b=4'hF -> busy for 4 cycles, done in cycle t+5, p=8'hE1, zero=0.
REQ-030 Start with a=4'h0, b=4'h9 -> p=8'h00 and zero=1 at done; then start with a=4'h1, b=4'h1 -> p=8'h01.
REQ-031 Start with a=4'h3, b=4'h5; pulse start with a=4'hF, b=4'hF during RUN -> p=8'h0F, with exactly one done pulse.
REQ-032 Assert rst during the third RUN cycle of 4'hA*4'hB -> no done pulse, all outputs at reset values next cycle; a following 4'hA*4'hB run -> p=8'h6E.
REQ-033 Hold start=1 continuously with a=4'h7, b=4'h6 -> done pulses every 5 cycles, each with p=8'h2A.
REQ-034 Exhaustive sweep of all 256 (a,b) pairs against a reference product -> zero mismatches, and latency equals 5 for every operation.

Source files
------------

// File: rtl/mul4_shift_add_pkg.sv
// Shared types and constants for the 4x4 shift-add multiplier.
package mul4_shift_add_pkg;
   localparam int OP_W   = 4;
   localparam int PROD_W = 2 * OP_W;
   localparam int STEPS  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mul4_shift_add_adder.sv
// 4-bit ripple-carry adder with carry-in, carry-out and signed overflow flag.
// Purely combinational, zero latency; no flow control.
module ripple_adder4 (
   input  logic [3:0] n1,
   input  logic [3:0] n2,
   input  logic       Ci,
   output logic [3:0] s,
   output logic       Co,
   output logic       Overflow
);
   logic [4:0] c;

   assign c[0] = Ci;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = n1[i] ^ n2[i] ^ c[i];
      assign c[i+1] = (n1[i] & n2[i]) | (c[i] & (n1[i] ^ n2[i]));
   end

   assign Co       = c[4];
   assign Overflow = c[3] ^ c[4];
endmodule

// File: rtl/mul4_shift_add.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift per RUN cycle.
// Latency 5 cycles start->done; start is ignored while busy, accepted in IDLE or DONE.
module mul4_shift_add
   import mul4_shift_add_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] p,
   output logic              busy,
   output logic              done,
   output logic              zero
);
   localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

   state_t            state;
   logic [1:0]        step;
   logic [OP_W-1:0]   mcand;
   logic [OP_W-1:0]   acc_hi;
   logic [OP_W-1:0]   acc_lo;
   logic [OP_W-1:0]   addend;
   logic [OP_W-1:0]   sum;
   logic              carry;
   logic              ovf_unused;
   logic [PROD_W-1:0] shifted;
   logic              accept;

   assign addend  = acc_lo[0] ? mcand : '0;
   // Carry lands in the top bit of the shifted accumulator, so it is never dropped.
   assign shifted = {carry, sum, acc_lo[OP_W-1:1]};
   assign accept  = start && ((state == IDLE) || (state == DONE));

   ripple_adder4 u_adder (
      .n1       (acc_hi),
      .n2       (addend),
      .Ci       (1'b0),
      .s        (sum),
      .Co       (carry),
      .Overflow (ovf_unused)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         step   <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         p      <= '0;
         zero   <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (accept) begin
         state  <= RUN;
         step   <= '0;
         mcand  <= a;
         acc_hi <= '0;
         acc_lo <= b;
         p      <= '0;
         zero   <= 1'b1;
         busy   <= 1'b1;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            RUN: begin
               {acc_hi, acc_lo} <= shifted;
               step             <= step + 2'd1;
               if (step == LAST_STEP) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  p     <= shifted;
                  zero  <= (shifted == '0);
               end
            end
            DONE:    state <= IDLE;
            IDLE:    state <= IDLE;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul4_shift_add.sv
// Directed and exhaustive checks of the 4x4 shift-add multiplier.
module tb_mul4_shift_add;
   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] p;
   logic       busy;
   logic       done;
   logic       zero;

   int checks = 0;
   int errors = 0;

   mul4_shift_add dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .p     (p),
      .busy  (busy),
      .done  (done),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation (from IDLE or DONE) and follow it to its done pulse.
   task automatic do_mul(input logic [3:0] ia, input logic [3:0] ib,
                         input logic [7:0] exp_p, input string tag);
      int lat;
      int busy_cnt;
      a = ia;
      b = ib;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      chk({tag, " p_clear"}, 32'(p), 32'h0);
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 12) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd5);
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
      chk({tag, " p"}, 32'(p), 32'(exp_p));
      chk({tag, " zero"}, 32'(zero), 32'(exp_p == 8'h00));
   endtask

   initial begin
      int ndone;
      int done_cyc;
      logic [7:0] got_p;

      rst = 1'b1;
      start = 1'b1;
      a = 4'hF;
      b = 4'hF;
      repeat (3) tick();
      chk("rst p", 32'(p), 32'h0);
      chk("rst zero", 32'(zero), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      start = 1'b0;
      rst = 1'b0;
      tick();

      do_mul(4'hF, 4'hF, 8'hE1, "ff");
      repeat (3) begin
         tick();
         chk("idle hold p", 32'(p), 32'hE1);
         chk("idle busy", 32'(busy), 32'd0);
         chk("idle done", 32'(done), 32'd0);
      end

      do_mul(4'h0, 4'h9, 8'h00, "0x9");
      do_mul(4'h1, 4'h1, 8'h01, "1x1 b2b");
      repeat (2) tick();

      // start pulsed mid-run must be ignored
      a = 4'h3;
      b = 4'h5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 4'hF;
      b = 4'hF;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      done_cyc = 0;
      got_p = 8'h00;
      for (int cyc = 3; cyc < 14; cyc++) begin
         if (done) begin
            ndone++;
            done_cyc = cyc;
            got_p = p;
         end
         tick();
      end
      chk("ignore start ndone", 32'(ndone), 32'd1);
      chk("ignore start done_cyc", 32'(done_cyc), 32'd5);
      chk("ignore start p", 32'(got_p), 32'h0F);

      // reset in the third RUN cycle aborts without a done pulse
      a = 4'hA;
      b = 4'hB;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort p", 32'(p), 32'h0);
      chk("abort zero", 32'(zero), 32'd1);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      ndone = 0;
      repeat (8) begin
         if (done) ndone++;
         tick();
      end
      chk("abort no done", 32'(ndone), 32'd0);
      do_mul(4'hA, 4'hB, 8'h6E, "axb");
      repeat (2) tick();

      // start held high: back-to-back operations every 5 cycles
      a = 4'h7;
      b = 4'h6;
      start = 1'b1;
      tick();
      ndone = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         chk($sformatf("hold done c%0d", cyc), 32'(done), 32'((cyc % 5) == 0));
         if (done) begin
            ndone++;
            chk($sformatf("hold p c%0d", cyc), 32'(p), 32'h2A);
         end
         if ((cyc % 5) == 1) chk($sformatf("hold p_clear c%0d", cyc), 32'(p), 32'h0);
         tick();
      end
      chk("hold ndone", 32'(ndone), 32'd4);
      start = 1'b0;
      repeat (8) tick();

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            do_mul(4'(i), 4'(j), 8'(i * j), $sformatf("sweep %0dx%0d", i, j));
         end
      end
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
